// File: rtl/bcd2binary.sv
// bcd2binary -- sequential packed-BCD to unsigned binary converter.
//
// Reverse double-dabble: the BCD value is loaded above a zeroed binary
// field, then the whole register is shifted right one bit per clock. After
// each shift, every BCD nibble that reads 8 or more has 3 subtracted. After
// BIN_W iterations the low field holds the binary result.
//
// Parameters:
//   DIGITS    number of packed BCD digits (input width 4*DIGITS)
//   BIN_W     result width, 2^BIN_W must exceed 10^DIGITS - 1
//
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   conversion request, sampled only while idle
//   bcd_data   in   packed BCD, digit 0 in [3:0], captured on accept
//   busy       out  high while converting
//   done       out  one-cycle pulse, bin_data/err valid from this cycle
//   bin_data   out  result, held until the next done
//   err        out  invalid-digit flag, updated with done
//
// Optional feature: define BCD2BIN_CHECK_EN to flag nibbles above 9 at
// capture; a flagged conversion reports err=1 with bin_data=0. Without the
// macro err is tied low and invalid nibbles go through the datapath as-is.

module bcd2binary #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_data,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_data,
  output logic                  err
);

  localparam int unsigned SR_W  = 4*DIGITS + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sreg;
  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   corrected;
  logic [CNT_W-1:0]  cnt;

  // One iteration: shift right, then correct each BCD nibble that is >= 8.
  always_comb begin
    shifted   = sreg >> 1;
    corrected = shifted;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (shifted[BIN_W + 4*i +: 4] >= 4'd8)
        corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad_digit;
  logic invalid;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_data[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin_data <= '0;
`ifdef BCD2BIN_CHECK_EN
      invalid  <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= {bcd_data, {BIN_W{1'b0}}};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
`ifdef BCD2BIN_CHECK_EN
            invalid <= bad_digit;
`endif
          end
        end
        CONV: begin
          sreg <= corrected;
          if (cnt == LAST) begin
`ifdef BCD2BIN_CHECK_EN
            bin_data <= invalid ? '0 : corrected[BIN_W-1:0];
            err      <= invalid;
`else
            bin_data <= corrected[BIN_W-1:0];
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2binary.sv
// tb_bcd2binary -- directed self-checking bench for bcd2binary (defaults
// DIGITS=4, BIN_W=14). Inputs change and outputs are sampled 1 ns after
// the rising edge.

module tb_bcd2binary;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [15:0] bcd_data;
  logic        busy;
  logic        done;
  logic [13:0] bin_data;
  logic        err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bcd2binary #(.DIGITS(4), .BIN_W(14)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bcd_data  (bcd_data),
    .busy      (busy),
    .done      (done),
    .bin_data  (bin_data),
    .err       (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance edge by edge until done is seen; n is the number of edges
  // taken (-1 if none within the budget). gap flags busy dropping early.
  task automatic wait_done(output int n, output bit gap);
    n   = -1;
    gap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge sys_clk); #1;
      if (done) begin
        n = i;
        break;
      end
      if (!busy) gap = 1'b1;
    end
  endtask

  // Accept a conversion: start high across one edge, then low again.
  task automatic launch(input logic [15:0] value);
    bcd_data = value;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start    = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    bcd_data  = '0;
    #3;
    check_cnt++;
    if ({busy, done, bin_data, err} !== 17'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b bin=%0d err=%b, want all 0",
               busy, done, bin_data, err);
    else pass_cnt++;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check_cnt++;
    if (busy !== 1'b0)
      $display("FAIL reset_idle: busy=%b, want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int n;
    bit gap;
    launch(16'h1234);
    check_cnt++;
    if (busy !== 1'b1)
      $display("FAIL basic_busy_rise: busy=%b, want 1", busy);
    else pass_cnt++;
    wait_done(n, gap);
    check_cnt++;
    if (n !== 14)
      $display("FAIL basic_latency: edges=%0d, want 14", n);
    else pass_cnt++;
    check_cnt++;
    if (gap !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_busy_window: gap=%b busy_at_done=%b, want 0/0", gap, busy);
    else pass_cnt++;
    check_cnt++;
    if (bin_data !== 14'd1234 || err !== 1'b0)
      $display("FAIL basic_result: bin=%0d err=%b, want 1234/0", bin_data, err);
    else pass_cnt++;
    @(posedge sys_clk); #1;
    check_cnt++;
    if (done !== 1'b0 || bin_data !== 14'd1234)
      $display("FAIL basic_pulse_hold: done=%b bin=%0d, want 0/1234", done, bin_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n;
    bit gap;
    bcd_data = 16'h0000;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    bcd_data = 16'h9999;          // only the second accept should see this
    wait_done(n, gap);
    check_cnt++;
    if (n !== 14 || bin_data !== 14'd0)
      $display("FAIL b2b_first: edges=%0d bin=%0d, want 14/0", n, bin_data);
    else pass_cnt++;
    wait_done(n, gap);
    start = 1'b0;
    check_cnt++;
    if (n !== 15)
      $display("FAIL b2b_spacing: edges=%0d, want 15", n);
    else pass_cnt++;
    check_cnt++;
    if (bin_data !== 14'd9999 || err !== 1'b0)
      $display("FAIL b2b_second: bin=%0d err=%b, want 9999/0", bin_data, err);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    int n;
    int extra;
    bit gap;
    launch(16'h0042);
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
    end
    bcd_data = 16'h5555;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start    = 1'b0;
    wait_done(n, gap);
    check_cnt++;
    if (n !== 9 || bin_data !== 14'd42)
      $display("FAIL ignore_result: edges=%0d bin=%0d, want 9/42", n, bin_data);
    else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      if (done || busy) extra++;
    end
    check_cnt++;
    if (extra !== 0)
      $display("FAIL ignore_no_second: active_cycles=%0d, want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    int extra;
    bit gap;
    launch(16'h8765);
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
    end
    sys_rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({busy, done, bin_data, err} !== 17'd0)
      $display("FAIL midreset_async: busy=%b done=%b bin=%0d err=%b, want all 0",
               busy, done, bin_data, err);
    else pass_cnt++;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      if (done || busy) extra++;
    end
    check_cnt++;
    if (extra !== 0)
      $display("FAIL midreset_no_done: active_cycles=%0d, want 0", extra);
    else pass_cnt++;
    launch(16'h8765);
    wait_done(n, gap);
    check_cnt++;
    if (n !== 14 || bin_data !== 14'd8765 || err !== 1'b0)
      $display("FAIL midreset_retry: edges=%0d bin=%0d err=%b, want 14/8765/0",
               n, bin_data, err);
    else pass_cnt++;
  endtask

  task automatic test_digit_check;
    int n;
    bit gap;
`ifdef BCD2BIN_CHECK_EN
    launch(16'h12A4);
    wait_done(n, gap);
    check_cnt++;
    if (n !== 14 || err !== 1'b1 || bin_data !== 14'd0)
      $display("FAIL check_invalid: edges=%0d err=%b bin=%0d, want 14/1/0",
               n, err, bin_data);
    else pass_cnt++;
`endif
    launch(16'h0007);
    wait_done(n, gap);
    check_cnt++;
    if (n !== 14 || err !== 1'b0 || bin_data !== 14'd7)
      $display("FAIL check_valid: edges=%0d err=%b bin=%0d, want 14/0/7",
               n, err, bin_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid;
    test_digit_check;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
